sram_input_loader: RTL and testbench
====================================

// Module: sram_input_loader
// PURPOSE
//  Upstream stage of the compute DUT. Takes a valid/ready stream of 16-bit words and writes them
//  sequentially into the input SRAM, starting at address 0. It then launches the DUT with a
//  dut_run/dut_busy handshake and reports completion. It owns the input-SRAM write port while the DUT is idle.
// PARAMETERS
//  ADDR_W     12    SRAM address width
//  DATA_W     16    SRAM/stream data width
//  MAX_WORDS  4096  max words per load (<= 2**ADDR_W); a load is forced to end at this limit
// PORTS
//  clk                     in   1        rising-edge clock
//  reset                   in   1        synchronous, active-high reset
//  in_valid                in   1        stream word valid
//  in_data                 in   DATA_W   stream word
//  in_last                 in   1        marks final word of a load
//  in_ready                out  1        loader can accept a word
//  ldr_sram_write_enable   out  1        input-SRAM write strobe
//  ldr_sram_write_addr     out  ADDR_W   input-SRAM write address
//  ldr_sram_write_data     out  DATA_W   input-SRAM write data
//  dut_run                 out  1        DUT start request
//  dut_busy                in   1        DUT busy
//  word_count              out  ADDR_W+1 words written in current/last load
//  load_done               out  1        1-cycle pulse when DUT has finished
//  overflow                out  1        sticky; load hit MAX_WORDS without in_last
//  checksum                out  DATA_W   see CONFIGURATION
// BEHAVIOUR
//  Reset values: all outputs 0, state IDLE, counters 0. Reset applies from any state, including mid-load
//   and mid-DUT-run. A DUT that is already running is not aborted; the loader just stops driving dut_run.
//  FSM states: IDLE, LOAD, RUN_REQ, RUN_WAIT, FINISH.
//   IDLE:     in_ready = ~dut_busy. First accepted beat clears word_count/overflow/checksum, then -> LOAD.
//             If that beat also has in_last, go directly to RUN_REQ.
//   LOAD:     in_ready=1. An accepted beat (in_valid & in_ready) is the beat with in_last=1, or the MAX_WORDS-th
//             beat -> RUN_REQ.
//   RUN_REQ:  in_ready=0, dut_run=1; held until dut_busy=1 is sampled (may already be high) -> RUN_WAIT.
//   RUN_WAIT: dut_run=0. Wait for dut_busy=0 -> FINISH.
//   FINISH:   load_done=1 for exactly 1 cycle -> IDLE.
//  Write path: each accepted beat produces 1 registered write, 1-cycle latency: next cycle we=1,
//   addr=word_count (pre-increment), data=beat data; word_count increments in that same cycle.
//   No write occurs on cycles without an accepted beat. we=0 in all other cycles.
//  First dut_run cycle is >= 1 cycle after the final write strobe. The DUT never sees a partial load.
//  Limit: if the MAX_WORDS-th beat arrives without in_last, overflow<=1 and the load ends. Extra words are
//   not accepted (in_ready=0). Address never wraps.
//  in_last on a beat that is not accepted is ignored. in_valid outside IDLE/LOAD is ignored.
//  word_count holds its value after load_done until the next load begins.
// CONFIGURATION
//  LOADER_CHECKSUM_EN defined: checksum = running mod-2**DATA_W sum of accepted words. It is updated
//   together with word_count and holds after the load.
//  Not defined: no adder is built and checksum is tied to 0.
// TESTING
//  1 4 beats 0x1111,0x2222,0x3333,0x4444, last on 4th -> writes addr 0..3 each 1 cycle after accept;
//    dut_run high the cycle after the addr-3 write; word_count=4.
//  2 same data with in_valid gaps of 2 cycles -> exactly 4 writes, no strobe on gap cycles, same addrs.
//  3 dut_busy rises 5 cycles after dut_run -> dut_run held 5 cycles, low the cycle after busy is seen.
//    Busy drops 10 cycles later -> load_done pulses once, then in_ready=1.
//  4 MAX_WORDS=8, send 10 words without last -> 8 writes (addr 0..7), overflow=1,
//    in_ready=0 after the 8th accept, dut_run asserted.
//  5 reset in RUN_WAIT with dut_busy=1 -> next cycle: dut_run=0, we=0, word_count=0, in_ready=0.
//    After busy drops, in_ready=1.
//  6 LOADER_CHECKSUM_EN defined, words 0xFFFF,0x0002 (last) -> checksum=0x0001.
//    Without the macro -> checksum=0.

Source files
------------

// File: rtl/sram_input_loader.sv
`default_nettype none
// ============================================================================
// Module   : sram_input_loader
// Purpose  : Upstream stage of the compute DUT. Writes a valid/ready stream of
//            words into the input SRAM from address 0, launches the DUT with a
//            dut_run/dut_busy handshake, and pulses load_done when it finishes.
//            The loader owns the input-SRAM write port while the DUT is idle.
// Ports    : clk, reset (sync, active-high)
//            in_valid/in_data/in_last/in_ready     - input word stream
//            ldr_sram_write_enable/_addr/_data     - input-SRAM write port
//            dut_run (out) / dut_busy (in)         - DUT launch handshake
//            word_count  - words written in the current/last load
//            load_done   - 1-cycle pulse once the DUT has finished
//            overflow    - sticky, load hit MAX_WORDS without in_last
//            checksum    - running sum of accepted words (0 when disabled)
// Options  : LOADER_CHECKSUM_EN - define to build the running-sum checksum;
//            without it checksum is tied to 0 and no adder is built.
// Revision : 1.0 - initial release
// ============================================================================
module sram_input_loader #(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 16,
  parameter int MAX_WORDS = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              ldr_sram_write_enable,
  output logic [ADDR_W-1:0] ldr_sram_write_addr,
  output logic [DATA_W-1:0] ldr_sram_write_data,
  output logic              dut_run,
  input  logic              dut_busy,
  output logic [ADDR_W:0]   word_count,
  output logic              load_done,
  output logic              overflow,
  output logic [DATA_W-1:0] checksum
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    RUN_REQ  = 3'd2,
    RUN_WAIT = 3'd3,
    FINISH   = 3'd4
  } state_t;

  // word_count value seen while the final permitted beat is being accepted
  localparam logic [ADDR_W:0] LAST_BEAT = (ADDR_W+1)'(MAX_WORDS - 1);

  state_t            state;
  logic              accept;
  logic              first_beat;
  logic              limit_hit;
  logic              end_load;
  logic [ADDR_W:0]   count_base;

  // Ready is gated by reset so no beat is ever acknowledged while the
  // registers are being cleared. In IDLE we refuse data while a DUT that
  // survived a reset is still busy, so the SRAM is never overwritten under it.
  assign in_ready   = ~reset & (((state == IDLE) & ~dut_busy) | (state == LOAD));
  assign accept     = in_valid & in_ready;

  // The first beat of a load restarts counting from zero, so the previous
  // load's word_count can be held for observation until then.
  assign first_beat = (state == IDLE);
  assign count_base = first_beat ? '0 : word_count;
  assign limit_hit  = (count_base == LAST_BEAT);
  assign end_load   = in_last | limit_hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      state                 <= IDLE;
      ldr_sram_write_enable <= 1'b0;
      ldr_sram_write_addr   <= '0;
      ldr_sram_write_data   <= '0;
      dut_run               <= 1'b0;
      word_count            <= '0;
      load_done             <= 1'b0;
      overflow              <= 1'b0;
    end else begin
      ldr_sram_write_enable <= 1'b0;
      load_done             <= 1'b0;

      if (accept) begin
        ldr_sram_write_enable <= 1'b1;
        ldr_sram_write_addr   <= count_base[ADDR_W-1:0];
        ldr_sram_write_data   <= in_data;
        word_count            <= count_base + 1'b1;
        // Overflow can only become 1 on the final beat of a load, so a
        // plain assignment both clears it on the first beat and sets it
        // when the limit is reached without in_last.
        overflow              <= limit_hit & ~in_last;
        state                 <= end_load ? RUN_REQ : LOAD;
      end

      case (state)
        RUN_REQ: begin
          // dut_run rises one cycle after entry, i.e. after the final write
          // strobe, and is held until busy is sampled while it is high.
          if (!dut_run) begin
            dut_run <= 1'b1;
          end else if (dut_busy) begin
            dut_run <= 1'b0;
            state   <= RUN_WAIT;
          end
        end
        RUN_WAIT: begin
          if (!dut_busy) begin
            load_done <= 1'b1;
            state     <= FINISH;
          end
        end
        FINISH: begin
          state <= IDLE;
        end
        default: begin
        end
      endcase
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] sum_base;

  assign sum_base = first_beat ? '0 : checksum;

  always_ff @(posedge clk) begin
    if (reset) begin
      checksum <= '0;
    end else if (accept) begin
      checksum <= sum_base + in_data;
    end
  end
`else
  assign checksum = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sram_input_loader.sv
`default_nettype none
module tb_sram_input_loader;

  localparam int AW   = 12;
  localparam int DW   = 16;
  localparam int MAXW = 8;

  logic          clk      = 1'b0;
  logic          reset    = 1'b1;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data  = '0;
  logic          in_last  = 1'b0;
  logic          dut_busy = 1'b0;
  logic          in_ready;
  logic          we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic          run;
  logic [AW:0]   wc;
  logic          done;
  logic          ovf;
  logic [DW-1:0] ck;

  sram_input_loader #(
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .MAX_WORDS(MAXW)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .in_valid             (in_valid),
    .in_data              (in_data),
    .in_last              (in_last),
    .in_ready             (in_ready),
    .ldr_sram_write_enable(we),
    .ldr_sram_write_addr  (waddr),
    .ldr_sram_write_data  (wdata),
    .dut_run              (run),
    .dut_busy             (dut_busy),
    .word_count           (wc),
    .load_done            (done),
    .overflow             (ovf),
    .checksum             (ck)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] eck(input logic [15:0] s);
`ifdef LOADER_CHECKSUM_EN
    return s;
`else
    return 16'h0000;
`endif
  endfunction

  // ---------------- table-driven directed vectors ----------------
  typedef struct {
    logic        v;
    logic [15:0] d;
    logic        l;
    logic        b;
    logic        rdy;
    logic        we;
    logic [11:0] a;
    logic [15:0] wd;
    logic        run;
    logic        done;
    logic        ovf;
    logic [12:0] wc;
    logic [15:0] ck;
  } vec_t;

  vec_t tbl[$];

  function automatic void row(input int v, input int d, input int l, input int b,
                              input int rdy, input int w, input int a, input int wd,
                              input int rn, input int dn, input int ov, input int cnt,
                              input int sum);
    vec_t r;
    r = '{1'(v), 16'(d), 1'(l), 1'(b), 1'(rdy), 1'(w), 12'(a), 16'(wd),
          1'(rn), 1'(dn), 1'(ov), 13'(cnt), eck(16'(sum))};
    tbl.push_back(r);
  endfunction

  function automatic int sum1(input int k);  // 0x1111 + 0x2222 + ... (k terms)
    return 32'h1111 * k * (k + 1) / 2;
  endfunction

  function automatic int sum4(input int k);  // 0x1000 + 0x1001 + ... (k terms)
    return k * 32'h1000 + k * (k - 1) / 2;
  endfunction

  task automatic apply(input int i);
    vec_t r;
    r = tbl[i];
    @(posedge clk); #1;
    in_valid = r.v; in_data = r.d; in_last = r.l; dut_busy = r.b;
    @(negedge clk);
    chk($sformatf("row%0d in_ready", i), 32'(in_ready), 32'(r.rdy));
    chk($sformatf("row%0d we", i), 32'(we), 32'(r.we));
    if (r.we) begin
      chk($sformatf("row%0d addr", i), 32'(waddr), 32'(r.a));
      chk($sformatf("row%0d wdata", i), 32'(wdata), 32'(r.wd));
    end
    chk($sformatf("row%0d dut_run", i), 32'(run), 32'(r.run));
    chk($sformatf("row%0d load_done", i), 32'(done), 32'(r.done));
    chk($sformatf("row%0d overflow", i), 32'(ovf), 32'(r.ovf));
    chk($sformatf("row%0d word_count", i), 32'(wc), 32'(r.wc));
    chk($sformatf("row%0d checksum", i), 32'(ck), 32'(r.ck));
  endtask

  task automatic run_handshake(input string nm);
    int n;
    n = 0;
    while (!run && n < 20) begin @(posedge clk); #1; n++; end
    chk({nm, " dut_run seen"}, 32'(run), 32'd1);
    dut_busy = 1'b1;
    @(posedge clk); #1;
    dut_busy = 1'b0;
    n = 0;
    while (!done && n < 20) begin @(negedge clk); n++; end
    chk({nm, " load_done seen"}, 32'(done), 32'd1);
    @(posedge clk); #1;
  endtask

  // ---------------- random phase: reference model ----------------
  bit          mon_en   = 0;
  bit          pend     = 0;
  int          pend_addr;
  logic [15:0] pend_data;
  logic [15:0] psum;
  bit          in_load  = 0;
  bit          awaiting = 0;
  int          beats    = 0;
  logic [15:0] msum     = '0;
  bit          exp_ovf  = 0;
  int          rsp      = 0;
  int          rcnt     = 0;

  // Emulated DUT: random start delay, random busy length.
  task automatic respond();
    case (rsp)
      0: if (run) begin rcnt = $urandom_range(0, 4); rsp = 1; end
      1: if (rcnt == 0) begin dut_busy = 1'b1; rcnt = $urandom_range(0, 6); rsp = 2; end
         else rcnt--;
      default: if (rcnt == 0) begin dut_busy = 1'b0; rsp = 0; end
               else rcnt--;
    endcase
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (pend) begin
        chk("rnd we", 32'(we), 32'd1);
        chk("rnd addr", 32'(waddr), pend_addr);
        chk("rnd wdata", 32'(wdata), 32'(pend_data));
        chk("rnd word_count", 32'(wc), pend_addr + 1);
        chk("rnd checksum", 32'(ck), 32'(eck(psum)));
      end else begin
        chk("rnd no write", 32'(we), 32'd0);
      end
      chk("rnd in_ready", 32'(in_ready), 32'(!awaiting));
      if (run) chk("rnd dut_run legal", 32'(awaiting && !pend), 32'd1);
      if (done) begin
        chk("rnd load_done expected", 32'(awaiting), 32'd1);
        chk("rnd final word_count", 32'(wc), beats);
        chk("rnd final overflow", 32'(ovf), 32'(exp_ovf));
        chk("rnd final checksum", 32'(ck), 32'(eck(msum)));
        awaiting = 0;
      end
      pend = in_valid && in_ready;
      if (pend) begin
        if (!in_load) begin in_load = 1; beats = 0; msum = '0; end
        pend_addr = beats;
        pend_data = in_data;
        beats++;
        msum = msum + in_data;
        psum = msum;
        if (in_last || beats == MAXW) begin
          in_load  = 0;
          awaiting = 1;
          exp_ovf  = !in_last;
        end
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int n;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset in_ready", 32'(in_ready), 32'd0);
    chk("reset we", 32'(we), 32'd0);
    chk("reset dut_run", 32'(run), 32'd0);
    chk("reset load_done", 32'(done), 32'd0);
    chk("reset overflow", 32'(ovf), 32'd0);
    chk("reset word_count", 32'(wc), 32'd0);
    chk("reset checksum", 32'(ck), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // 4 back-to-back beats, dut_run held until busy, busy for 10 cycles
    row(1, 'h1111, 0, 0, 1, 0, 0, 0,      0, 0, 0, 0, 0);
    row(1, 'h2222, 0, 0, 1, 1, 0, 'h1111, 0, 0, 0, 1, 'h1111);
    row(1, 'h3333, 0, 0, 1, 1, 1, 'h2222, 0, 0, 0, 2, 'h3333);
    row(1, 'h4444, 1, 0, 1, 1, 2, 'h3333, 0, 0, 0, 3, 'h6666);
    row(0, 0,      0, 0, 0, 1, 3, 'h4444, 0, 0, 0, 4, 'hAAAA);
    for (int i = 0; i < 4; i++) row(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 4, 'hAAAA);
    row(0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 4, 'hAAAA);
    for (int i = 0; i < 9; i++) row(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 4, 'hAAAA);
    row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4, 'hAAAA);
    row(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 4, 'hAAAA);
    row(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 4, 'hAAAA);

    // same data with 2-cycle valid gaps
    for (int k = 0; k < 4; k++) begin
      row(1, 'h1111 * (k + 1), (k == 3) ? 1 : 0, 0, 1, 0, 0, 0, 0, 0, 0,
          (k == 0) ? 4 : k, (k == 0) ? 'hAAAA : sum1(k));
      row(0, 0, 0, 0, (k == 3) ? 0 : 1, 1, k, 'h1111 * (k + 1), 0, 0, 0, k + 1, sum1(k + 1));
      if (k < 3) row(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, k + 1, sum1(k + 1));
    end
    row(0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 4, 'hAAAA);
    row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4, 'hAAAA);
    row(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 4, 'hAAAA);
    row(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 4, 'hAAAA);

    // 10 words without last against an 8-word limit
    row(1, 'h1000, 0, 0, 1, 0, 0, 0, 0, 0, 0, 4, 'hAAAA);
    for (int i = 1; i < 8; i++)
      row(1, 'h1000 + i, 0, 0, 1, 1, i - 1, 'h1000 + i - 1, 0, 0, 0, i, sum4(i));
    row(1, 'h1008, 0, 0, 0, 1, 7, 'h1007, 0, 0, 1, 8, sum4(8));
    row(1, 'h1009, 0, 0, 0, 0, 0, 0,      1, 0, 1, 8, sum4(8));
    row(0, 0,      0, 1, 0, 0, 0, 0,      1, 0, 1, 8, sum4(8));
    row(0, 0,      0, 0, 0, 0, 0, 0,      0, 0, 1, 8, sum4(8));
    row(0, 0,      0, 0, 0, 0, 0, 0,      0, 1, 1, 8, sum4(8));
    row(0, 0,      0, 0, 1, 0, 0, 0,      0, 0, 1, 8, sum4(8));

    // checksum wrap: 0xFFFF + 0x0002; overflow cleared by the new load
    row(1, 'hFFFF, 0, 0, 1, 0, 0, 0,      0, 0, 1, 8, sum4(8));
    row(1, 'h0002, 1, 0, 1, 1, 0, 'hFFFF, 0, 0, 0, 1, 'hFFFF);
    row(0, 0,      0, 0, 0, 1, 1, 'h0002, 0, 0, 0, 2, 'h0001);
    row(0, 0,      0, 0, 0, 0, 0, 0,      1, 0, 0, 2, 'h0001);
    row(0, 0,      0, 1, 0, 0, 0, 0,      1, 0, 0, 2, 'h0001);
    row(0, 0,      0, 0, 0, 0, 0, 0,      0, 0, 0, 2, 'h0001);
    row(0, 0,      0, 0, 0, 0, 0, 0,      0, 1, 0, 2, 'h0001);
    row(0, 0,      0, 0, 1, 0, 0, 0,      0, 0, 0, 2, 'h0001);

    for (int i = 0; i < tbl.size(); i++) apply(i);

    // reset while the DUT is running
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 16'h5A5A; in_last = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    n = 0;
    while (!run && n < 20) begin @(posedge clk); #1; n++; end
    chk("t5 dut_run seen", 32'(run), 32'd1);
    dut_busy = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("t5 dut_run released", 32'(run), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("t5 post-reset dut_run", 32'(run), 32'd0);
    chk("t5 post-reset we", 32'(we), 32'd0);
    chk("t5 post-reset word_count", 32'(wc), 32'd0);
    chk("t5 post-reset in_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5 busy in_ready", 32'(in_ready), 32'd0);
      chk("t5 busy dut_run", 32'(run), 32'd0);
    end
    @(posedge clk); #1;
    dut_busy = 1'b0;
    @(negedge clk);
    chk("t5 idle in_ready", 32'(in_ready), 32'd1);
    chk("t5 no load_done", 32'(done), 32'd0);

    // reset in the middle of a load, then a fresh 1-word load
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 16'h0007; in_last = 1'b0;
    @(posedge clk); #1;
    in_data = 16'h0008;
    @(posedge clk); #1;
    in_valid = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; in_valid = 1'b1; in_data = 16'h0009; in_last = 1'b1;
    @(negedge clk);
    chk("mid-load reset we", 32'(we), 32'd0);
    chk("mid-load reset word_count", 32'(wc), 32'd0);
    chk("mid-load reset in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk);
    chk("reload we", 32'(we), 32'd1);
    chk("reload addr", 32'(waddr), 32'd0);
    chk("reload wdata", 32'(wdata), 32'h0009);
    chk("reload checksum", 32'(ck), 32'(eck(16'h0009)));
    run_handshake("reload");

    // randomized traffic against the reference model
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    pend = 0; in_load = 0; awaiting = 0; beats = 0; msum = '0; rsp = 0;
    mon_en = 1;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = 16'($urandom);
      in_last  = ($urandom_range(0, 9) == 0);
      respond();
    end
    n = 0;
    while ((in_load || awaiting) && n < 400) begin
      @(posedge clk); #1;
      in_valid = in_load;
      in_last  = 1'b1;
      in_data  = 16'($urandom);
      respond();
      n++;
    end
    in_valid = 1'b0; in_last = 1'b0;
    chk("rnd drained", 32'(in_load || awaiting), 32'd0);
    repeat (3) @(posedge clk);
    mon_en = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
